// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: ALU control codes, operand-select
// encodings and the packed record held in the stage's output register.
// Ports: none (package).
package execute_stage_pkg;

  localparam logic [3:0] EXECOP_ADD  = 4'h0;
  localparam logic [3:0] EXECOP_SUB  = 4'h1;
  localparam logic [3:0] EXECOP_SLL  = 4'h2;
  localparam logic [3:0] EXECOP_SLT  = 4'h3;
  localparam logic [3:0] EXECOP_SLTU = 4'h4;
  localparam logic [3:0] EXECOP_XOR  = 4'h5;
  localparam logic [3:0] EXECOP_SRL  = 4'h6;
  localparam logic [3:0] EXECOP_SRA  = 4'h7;
  localparam logic [3:0] EXECOP_OR   = 4'h8;
  localparam logic [3:0] EXECOP_AND  = 4'h9;

  localparam logic OPSEL_RS1 = 1'b0;
  localparam logic OPSEL_PC  = 1'b1;
  localparam logic OPSEL_RS2 = 1'b0;
  localparam logic OPSEL_IMM = 1'b1;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;
  } ex_out_t;

endpackage

// File: rtl/execute_stage_if.sv
// Bundle of decode-side, writeback-side and MEM-side signals of the execute stage.
// Ports: none; modport slave = the stage, modport master = the surrounding pipeline.
interface execute_stage_if #(
  parameter int STALL_CNT_W = 16
) ();
  logic                   flush_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [31:0]            in_pc_i;
  logic [31:0]            in_rs1_data_i;
  logic [31:0]            in_rs2_data_i;
  logic [31:0]            in_imm_i;
  logic [4:0]             in_rs1_addr_i;
  logic [4:0]             in_rs2_addr_i;
  logic [4:0]             in_rd_addr_i;
  logic                   in_rd_we_i;
  logic [3:0]             in_alu_ctrl_i;
  logic                   in_op1_sel_i;
  logic                   in_op2_sel_i;
  logic                   wb_we_i;
  logic [4:0]             wb_rd_addr_i;
  logic [31:0]            wb_data_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [31:0]            out_result_o;
  logic [31:0]            out_store_data_o;
  logic [4:0]             out_rd_addr_o;
  logic                   out_rd_we_o;
  logic                   out_illegal_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;

  modport slave (
    input  flush_i, in_valid_i, in_pc_i, in_rs1_data_i, in_rs2_data_i, in_imm_i,
           in_rs1_addr_i, in_rs2_addr_i, in_rd_addr_i, in_rd_we_i, in_alu_ctrl_i,
           in_op1_sel_i, in_op2_sel_i, wb_we_i, wb_rd_addr_i, wb_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_result_o, out_store_data_o, out_rd_addr_o,
           out_rd_we_o, out_illegal_o, stall_cnt_o
  );

  modport master (
    output flush_i, in_valid_i, in_pc_i, in_rs1_data_i, in_rs2_data_i, in_imm_i,
           in_rs1_addr_i, in_rs2_addr_i, in_rd_addr_i, in_rd_we_i, in_alu_ctrl_i,
           in_op1_sel_i, in_op2_sel_i, wb_we_i, wb_rd_addr_i, wb_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_result_o, out_store_data_o, out_rd_addr_o,
           out_rd_we_o, out_illegal_o, stall_cnt_o
  );
endinterface

// File: rtl/execute_stage_alu.sv
// Combinational 32-bit integer ALU; results wrap mod 2^32, shift amount is i_op2[4:0].
// Ports: i_op1/i_op2 operands, i_ctrl EXECOP_* code, o_result (0 for unknown codes).
module execute_stage_alu
  import execute_stage_pkg::*;
(
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic [3:0]  i_ctrl,
  output logic [31:0] o_result
);
  logic [4:0] w_shamt;
  assign w_shamt = i_op2[4:0];

  always_comb begin
    o_result = '0;
    case (i_ctrl)
      EXECOP_ADD:  o_result = i_op1 + i_op2;
      EXECOP_SUB:  o_result = i_op1 + ~i_op2 + 32'd1;
      EXECOP_SLL:  o_result = i_op1 << w_shamt;
      EXECOP_SLT:  o_result = {31'd0, $signed(i_op1) < $signed(i_op2)};
      EXECOP_SLTU: o_result = {31'd0, i_op1 < i_op2};
      EXECOP_XOR:  o_result = i_op1 ^ i_op2;
      EXECOP_SRL:  o_result = i_op1 >> w_shamt;
      EXECOP_SRA:  o_result = $unsigned($signed(i_op1) >>> w_shamt);
      EXECOP_OR:   o_result = i_op1 | i_op2;
      EXECOP_AND:  o_result = i_op1 & i_op2;
      default:     o_result = '0;
    endcase
  end
endmodule

// File: rtl/execute_stage.sv
// Purpose: single-entry EX stage; selects operands, runs the ALU, registers result/rd/store data.
// Latency: 1 cycle from accept to out_*; back-to-back issue yields one result per cycle.
// Backpressure: in_ready_o = ~out_valid_o | out_ready_i; output held stable while stalled.
// Ports: clk_i, rst_ni (async active-low), bus (execute_stage_if.slave: decode in_*,
//   writeback wb_*, MEM out_*, flush_i, stall_cnt_o saturating stall counter).
// Config macro: EXEC_FWD_EN enables operand forwarding from the out register and wb port.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input logic           clk_i,
  input logic           rst_ni,
  execute_stage_if.slave bus
);
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

  logic                   r_valid;
  ex_out_t                r_out;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_legal;
  logic [31:0] w_rs1;
  logic [31:0] w_rs2;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [31:0] w_alu_result;
  ex_out_t     w_next;

  assign w_in_ready = ~r_valid | bus.out_ready_i;
  assign w_accept   = bus.in_valid_i & w_in_ready;

`ifdef EXEC_FWD_EN
  // The instruction sitting in the out register is younger than the one on the
  // writeback port, so it wins. x0 is hard-wired and never forwarded.
  always_comb begin
    w_rs1 = bus.in_rs1_data_i;
    if (bus.in_rs1_addr_i != 5'd0) begin
      if (r_valid && r_out.rd_we && (r_out.rd_addr == bus.in_rs1_addr_i))
        w_rs1 = r_out.result;
      else if (bus.wb_we_i && (bus.wb_rd_addr_i == bus.in_rs1_addr_i))
        w_rs1 = bus.wb_data_i;
    end
  end

  always_comb begin
    w_rs2 = bus.in_rs2_data_i;
    if (bus.in_rs2_addr_i != 5'd0) begin
      if (r_valid && r_out.rd_we && (r_out.rd_addr == bus.in_rs2_addr_i))
        w_rs2 = r_out.result;
      else if (bus.wb_we_i && (bus.wb_rd_addr_i == bus.in_rs2_addr_i))
        w_rs2 = bus.wb_data_i;
    end
  end
`else
  // Without forwarding the decoder resolves hazards; index and wb ports are unused.
  assign w_rs1 = bus.in_rs1_data_i;
  assign w_rs2 = bus.in_rs2_data_i;

  logic w_unused;
  assign w_unused = &{1'b0, bus.in_rs1_addr_i, bus.in_rs2_addr_i,
                      bus.wb_we_i, bus.wb_rd_addr_i, bus.wb_data_i};
`endif

  assign w_op1 = (bus.in_op1_sel_i == OPSEL_PC)  ? bus.in_pc_i  : w_rs1;
  assign w_op2 = (bus.in_op2_sel_i == OPSEL_IMM) ? bus.in_imm_i : w_rs2;

  execute_stage_alu u_alu (
    .i_op1    (w_op1),
    .i_op2    (w_op2),
    .i_ctrl   (bus.in_alu_ctrl_i),
    .o_result (w_alu_result)
  );

  assign w_legal = bus.in_alu_ctrl_i inside {EXECOP_ADD, EXECOP_SUB, EXECOP_SLL, EXECOP_SLT,
                                             EXECOP_SLTU, EXECOP_XOR, EXECOP_SRL, EXECOP_SRA,
                                             EXECOP_OR, EXECOP_AND};

  always_comb begin
    w_next            = '0;
    w_next.result     = w_legal ? w_alu_result : 32'd0;
    w_next.store_data = w_rs2;
    w_next.rd_addr    = bus.in_rd_addr_i;
    w_next.rd_we      = bus.in_rd_we_i;
    w_next.illegal    = ~w_legal;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid     <= 1'b0;
      r_out       <= '0;
      r_stall_cnt <= '0;
    end else begin
      // Stall accounting is independent of flush.
      if (r_valid && !bus.out_ready_i && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + STALL_ONE;

      if (bus.flush_i) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_out   <= w_next;
      end else if (bus.out_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready_o       = w_in_ready;
  assign bus.out_valid_o      = r_valid;
  assign bus.out_result_o     = r_out.result;
  assign bus.out_store_data_o = r_out.store_data;
  assign bus.out_rd_addr_o    = r_out.rd_addr;
  assign bus.out_rd_we_o      = r_out.rd_we;
  assign bus.out_illegal_o    = r_out.illegal;
  assign bus.stall_cnt_o      = r_stall_cnt;
endmodule
